mem_port_arbiter: RTL and testbench

//  Two-requester arbiter/sequencer in front of the unified byte-addressed data memory (program at 0, data from 1000).

---
 rtl/mem_port_arbiter_if.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports (instruction fetch, load/store) and the
// shared memory port of mem_port_arbiter.
//   slave  : arbiter view (requests and memory read data in, grants/responses/strobes out)
//   master : environment view (requesters plus memory)
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   // instruction fetch port
   logic          if_req;
   logic [AW-1:0] if_adr;
   logic          if_gnt;
   logic          if_valid;
   logic [DW-1:0] if_rdata;
   logic          if_err;
   // load/store port
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_adr;
   logic [DW-1:0] d_wdata;
   logic          d_gnt;
   logic          d_valid;
   logic [DW-1:0] d_rdata;
   logic          d_err;
   // shared memory port
   logic [AW-1:0] adr;
   logic [DW-1:0] d_in;
   logic          mrd;
   logic          mwr;
   logic [DW-1:0] d_out;

   modport slave (
      input  if_req, if_adr,
      output if_gnt, if_valid, if_rdata, if_err,
      input  d_req, d_we, d_adr, d_wdata,
      output d_gnt, d_valid, d_rdata, d_err,
      output adr, d_in, mrd, mwr,
      input  d_out
   );

   modport master (
      output if_req, if_adr,
      input  if_gnt, if_valid, if_rdata, if_err,
      output d_req, d_we, d_adr, d_wdata,
      input  d_gnt, d_valid, d_rdata, d_err,
      input  adr, d_in, mrd, mwr,
      output d_out
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-addressed memory port between instruction
// fetch (IF) and load/store (D). A request seen in IDLE is latched and played
// out in a single ACCESS cycle; the end of ACCESS captures read data and pulses
// the owner's valid. Misaligned or out-of-range accesses never strobe memory
// and answer with err=1, rdata=0.
// Configuration macro ARB_RR_EN: when defined, simultaneous requests are
// resolved round-robin (port not granted last wins); when undefined, D always
// beats IF.
module mem_port_arbiter #(
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int MEM_BYTES = 65536
) (
   input  logic               clk,
   input  logic               rst,
   mem_port_arbiter_if.slave  bus
);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic          owner_d_q, owner_d_d;   // 1: D port owns the access, 0: IF port
   logic          we_q, we_d;
   logic          legal_q, legal_d;
   logic [AW-1:0] adr_q, adr_d;
   logic [DW-1:0] d_in_q, d_in_d;
   logic          mrd_q, mrd_d;
   logic          mwr_q, mwr_d;
   logic          if_gnt_q, if_gnt_d;
   logic          if_valid_q, if_valid_d;
   logic          if_err_q, if_err_d;
   logic [DW-1:0] if_rdata_q, if_rdata_d;
   logic          d_gnt_q, d_gnt_d;
   logic          d_valid_q, d_valid_d;
   logic          d_err_q, d_err_d;
   logic [DW-1:0] d_rdata_q, d_rdata_d;
`ifdef ARB_RR_EN
   logic          rr_d_next_q, rr_d_next_d;  // 1: D wins the next tie, 0: IF wins
`endif

   logic          win_d_s;
   logic          win_we_s;
   logic [AW-1:0] win_adr_s;
   logic [DW-1:0] win_wdata_s;
   logic          win_legal_s;

   // Word access is legal when aligned and its last byte lies inside memory;
   // the extra top bit makes a wrap past 2^AW compare as out of range.
   function automatic logic addr_legal(input logic [AW-1:0] a);
      logic [AW:0] last_byte;
      last_byte = {1'b0, a} + (AW+1)'(2'd3);
      return (a[1:0] == 2'b00) && (last_byte < (AW+1)'(MEM_BYTES));
   endfunction

   // Pick the winning requester and gather its request fields.
   always_comb begin
      win_d_s = 1'b0;
      if (bus.d_req && bus.if_req) begin
`ifdef ARB_RR_EN
         win_d_s = rr_d_next_q;
`else
         win_d_s = 1'b1;
`endif
      end else begin
         win_d_s = bus.d_req;
      end
      win_we_s    = win_d_s & bus.d_we;
      win_adr_s   = win_d_s ? bus.d_adr : bus.if_adr;
      win_wdata_s = win_d_s ? bus.d_wdata : {DW{1'b0}};
      win_legal_s = addr_legal(win_adr_s);
   end

   // Next-state and next-output computation for the IDLE/ACCESS sequencer.
   always_comb begin
      state_d    = state_q;
      owner_d_d  = owner_d_q;
      we_d       = we_q;
      legal_d    = legal_q;
      adr_d      = {AW{1'b0}};
      d_in_d     = {DW{1'b0}};
      mrd_d      = 1'b0;
      mwr_d      = 1'b0;
      if_gnt_d   = 1'b0;
      if_valid_d = 1'b0;
      if_err_d   = 1'b0;
      if_rdata_d = if_rdata_q;
      d_gnt_d    = 1'b0;
      d_valid_d  = 1'b0;
      d_err_d    = 1'b0;
      d_rdata_d  = d_rdata_q;
`ifdef ARB_RR_EN
      rr_d_next_d = rr_d_next_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.if_req || bus.d_req) begin
               state_d   = ST_ACCESS;
               owner_d_d = win_d_s;
               we_d      = win_we_s;
               legal_d   = win_legal_s;
               if_gnt_d  = ~win_d_s;
               d_gnt_d   = win_d_s;
               if (win_legal_s) begin
                  adr_d  = win_adr_s;
                  d_in_d = win_wdata_s;
                  mrd_d  = ~win_we_s;
                  mwr_d  = win_we_s;
               end else begin
                  adr_d  = {AW{1'b0}};
                  d_in_d = {DW{1'b0}};
                  mrd_d  = 1'b0;
                  mwr_d  = 1'b0;
               end
`ifdef ARB_RR_EN
               rr_d_next_d = ~win_d_s;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            state_d = ST_IDLE;
            if (owner_d_q) begin
               d_valid_d = 1'b1;
               d_err_d   = ~legal_q;
               d_rdata_d = (legal_q && !we_q) ? bus.d_out : {DW{1'b0}};
            end else begin
               if_valid_d = 1'b1;
               if_err_d   = ~legal_q;
               if_rdata_d = legal_q ? bus.d_out : {DW{1'b0}};
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs; synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         owner_d_q  <= 1'b0;
         we_q       <= 1'b0;
         legal_q    <= 1'b0;
         adr_q      <= {AW{1'b0}};
         d_in_q     <= {DW{1'b0}};
         mrd_q      <= 1'b0;
         mwr_q      <= 1'b0;
         if_gnt_q   <= 1'b0;
         if_valid_q <= 1'b0;
         if_err_q   <= 1'b0;
         if_rdata_q <= {DW{1'b0}};
         d_gnt_q    <= 1'b0;
         d_valid_q  <= 1'b0;
         d_err_q    <= 1'b0;
         d_rdata_q  <= {DW{1'b0}};
`ifdef ARB_RR_EN
         rr_d_next_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         owner_d_q  <= owner_d_d;
         we_q       <= we_d;
         legal_q    <= legal_d;
         adr_q      <= adr_d;
         d_in_q     <= d_in_d;
         mrd_q      <= mrd_d;
         mwr_q      <= mwr_d;
         if_gnt_q   <= if_gnt_d;
         if_valid_q <= if_valid_d;
         if_err_q   <= if_err_d;
         if_rdata_q <= if_rdata_d;
         d_gnt_q    <= d_gnt_d;
         d_valid_q  <= d_valid_d;
         d_err_q    <= d_err_d;
         d_rdata_q  <= d_rdata_d;
`ifdef ARB_RR_EN
         rr_d_next_q <= rr_d_next_d;
`endif
      end
   end

   assign bus.if_gnt   = if_gnt_q;
   assign bus.if_valid = if_valid_q;
   assign bus.if_err   = if_err_q;
   assign bus.if_rdata = if_rdata_q;
   assign bus.d_gnt    = d_gnt_q;
   assign bus.d_valid  = d_valid_q;
   assign bus.d_err    = d_err_q;
   assign bus.d_rdata  = d_rdata_q;
   assign bus.adr      = adr_q;
   assign bus.d_in     = d_in_q;
   assign bus.mrd      = mrd_q;
   // A reset arriving during a store ACCESS must keep the write from committing.
   assign bus.mwr      = mwr_q & rst;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a transaction-level reference model
// with its own copy of memory predicts every output each cycle, and directed
// scenarios pin the model with hand-computed literals.
module tb_mem_port_arbiter;
   localparam int AW        = 32;
   localparam int DW        = 32;
   localparam int MEM_BYTES = 65536;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_BYTES(MEM_BYTES)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] init_byte(input int i);
      if (i == 0) return 8'h13;
      else if (i < 4) return 8'h00;
      else return 8'(i) ^ 8'hA5;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- memory attached to the DUT ----------------
   logic [7:0]  mem [0:MEM_BYTES-1];
   logic [15:0] ba;
   assign ba        = bus.adr[15:0];
   assign bus.d_out = bus.mrd ? {mem[ba+16'd3], mem[ba+16'd2], mem[ba+16'd1], mem[ba]} : 32'd0;

   initial begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] = init_byte(i);
      forever begin
         @(posedge clk);
         if (bus.mwr) begin
            mem[ba]        = bus.d_in[7:0];
            mem[ba+16'd1]  = bus.d_in[15:8];
            mem[ba+16'd2]  = bus.d_in[23:16];
            mem[ba+16'd3]  = bus.d_in[31:24];
         end
      end
   end

   function automatic logic [31:0] mem_word(input int a);
      return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
   endfunction

   // ---------------- reference model ----------------
   logic [7:0]  ref_mem [0:MEM_BYTES-1];
   bit          ref_ready  = 1'b0;
   bit          model_live = 1'b0;
   bit          m_busy, m_own_d, m_we, m_legal;
`ifdef ARB_RR_EN
   bit          m_last_d;
`endif
   logic [31:0] m_adr, m_wdata, m_resp;
   logic        e_if_gnt, e_if_valid, e_if_err, e_d_gnt, e_d_valid, e_d_err, e_mrd, e_mwr;
   logic [31:0] e_if_rdata, e_d_rdata, e_adr, e_d_in;

   function automatic bit legal_fn(input logic [31:0] a);
      return (a % 32'd4 == 32'd0) && (longint'(a) + 64'd3 < longint'(MEM_BYTES));
   endfunction

   always @(posedge clk) begin
      if (!ref_ready) begin
         for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = init_byte(i);
         ref_ready = 1'b1;
      end
      if (!rst) begin
         model_live = 1'b1;
         m_busy = 1'b0;
`ifdef ARB_RR_EN
         m_last_d = 1'b1;
`endif
         {e_if_gnt, e_if_valid, e_if_err, e_d_gnt, e_d_valid, e_d_err, e_mrd, e_mwr} = 8'd0;
         e_if_rdata = 32'd0; e_d_rdata = 32'd0; e_adr = 32'd0; e_d_in = 32'd0;
      end else if (m_busy) begin
         m_busy = 1'b0;
         {e_if_gnt, e_d_gnt, e_mrd, e_mwr} = 4'd0;
         e_adr = 32'd0; e_d_in = 32'd0;
         m_resp = 32'd0;
         if (m_legal && !m_we)
            m_resp = {ref_mem[int'(m_adr)+3], ref_mem[int'(m_adr)+2], ref_mem[int'(m_adr)+1], ref_mem[int'(m_adr)]};
         if (m_legal && m_we)
            for (int b = 0; b < 4; b++) ref_mem[int'(m_adr)+b] = m_wdata[8*b +: 8];
         if (m_own_d) begin
            e_d_valid = 1'b1; e_d_err = !m_legal; e_d_rdata = m_resp;
         end else begin
            e_if_valid = 1'b1; e_if_err = !m_legal; e_if_rdata = m_resp;
         end
      end else begin
         {e_if_valid, e_if_err, e_d_valid, e_d_err} = 4'd0;
         if (bus.if_req || bus.d_req) begin
`ifdef ARB_RR_EN
            m_own_d  = (bus.if_req && bus.d_req) ? !m_last_d : bus.d_req;
            m_last_d = m_own_d;
`else
            m_own_d  = bus.d_req;
`endif
            m_busy  = 1'b1;
            m_adr   = m_own_d ? bus.d_adr : bus.if_adr;
            m_we    = m_own_d && bus.d_we;
            m_wdata = m_own_d ? bus.d_wdata : 32'd0;
            m_legal = legal_fn(m_adr);
            e_if_gnt = !m_own_d;
            e_d_gnt  = m_own_d;
            e_adr    = m_legal ? m_adr : 32'd0;
            e_d_in   = m_legal ? m_wdata : 32'd0;
            e_mrd    = m_legal && !m_we;
            e_mwr    = m_legal && m_we;
         end
      end
   end

   // Per-cycle comparison of every DUT output against the model.
   always @(posedge clk) begin
      #1;
      if (model_live) begin
         chk("if_gnt",   32'(bus.if_gnt),   32'(e_if_gnt));
         chk("if_valid", 32'(bus.if_valid), 32'(e_if_valid));
         chk("if_err",   32'(bus.if_err),   32'(e_if_err));
         chk("if_rdata", bus.if_rdata,      e_if_rdata);
         chk("d_gnt",    32'(bus.d_gnt),    32'(e_d_gnt));
         chk("d_valid",  32'(bus.d_valid),  32'(e_d_valid));
         chk("d_err",    32'(bus.d_err),    32'(e_d_err));
         chk("d_rdata",  bus.d_rdata,       e_d_rdata);
         chk("adr",      bus.adr,           e_adr);
         chk("d_in",     bus.d_in,          e_d_in);
         chk("mrd",      32'(bus.mrd),      32'(e_mrd));
         chk("mwr",      32'(bus.mwr),      32'(e_mwr));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic wait_gnt(input bit is_d, output int lat);
      lat = 0;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); #1;
         if ((is_d ? bus.d_gnt : bus.if_gnt) == 1'b1) begin
            lat = i;
            break;
         end
      end
      chk("gnt_seen", 32'(lat != 0), 32'd1);
   endtask

   task automatic wait_valid(input bit is_d, output int lat, output logic [31:0] rdata, output logic err);
      lat = 0; rdata = 32'd0; err = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); #1;
         if ((is_d ? bus.d_valid : bus.if_valid) == 1'b1) begin
            lat   = i;
            rdata = is_d ? bus.d_rdata : bus.if_rdata;
            err   = is_d ? bus.d_err : bus.if_err;
            break;
         end
      end
      chk("valid_seen", 32'(lat != 0), 32'd1);
   endtask

   task automatic do_if(input logic [31:0] a, output logic [31:0] rd, output logic er,
                        output int glat, output int vlat);
      @(negedge clk);
      bus.if_req = 1'b1; bus.if_adr = a;
      wait_gnt(1'b0, glat);
      @(negedge clk);
      bus.if_req = 1'b0;
      wait_valid(1'b0, vlat, rd, er);
   endtask

   task automatic do_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
      int glat, vlat;
      @(negedge clk);
      bus.d_req = 1'b1; bus.d_we = we; bus.d_adr = a; bus.d_wdata = wd;
      wait_gnt(1'b1, glat);
      @(negedge clk);
      bus.d_req = 1'b0;
      wait_valid(1'b1, vlat, rd, er);
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          glat, vlat, n_d, n_if, prev_v;
      bit          first_d;
      logic [31:0] b2b_exp [4];

      rst = 1'b0;
      bus.if_req = 1'b0; bus.if_adr = 32'd0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_adr = 32'd0; bus.d_wdata = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_if_rdata", bus.if_rdata, 32'd0);
      chk("rst_d_valid",  32'(bus.d_valid), 32'd0);
      chk("rst_adr",      bus.adr, 32'd0);
      chk("rst_strobes",  32'({bus.mrd, bus.mwr, bus.if_gnt, bus.d_gnt}), 32'd0);
      @(negedge clk); rst = 1'b1;
      repeat (2) @(negedge clk);

      // fetch from address 0
      do_if(32'd0, rd, er, glat, vlat);
      chk("fetch_rdata", rd, 32'h00000013);
      chk("fetch_err", 32'(er), 32'd0);
      chk("fetch_gnt_latency", 32'(glat), 32'd1);
      chk("fetch_valid_latency", 32'(vlat), 32'd1);
      repeat (2) @(negedge clk);

      // contention: both requesting for 6 cycles (last grant so far was IF)
      @(negedge clk);
      bus.if_req = 1'b1; bus.if_adr = 32'd0;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_adr = 32'd1000;
      n_d = 0; n_if = 0; first_d = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (bus.d_gnt) begin
            if (n_d + n_if == 0) first_d = 1'b1;
            n_d++;
         end
         if (bus.if_gnt) n_if++;
      end
      @(negedge clk);
      bus.if_req = 1'b0; bus.d_req = 1'b0;
`ifdef ARB_RR_EN
      chk("contend_d_grants", 32'(n_d), 32'd2);
      chk("contend_if_grants", 32'(n_if), 32'd1);
`else
      chk("contend_d_grants", 32'(n_d), 32'd3);
      chk("contend_if_grants", 32'(n_if), 32'd0);
`endif
      chk("contend_first_is_d", 32'(first_d), 32'd1);
      repeat (2) @(negedge clk);

      // store then load
      do_d(1'b1, 32'd1000, 32'hDEADBEEF, rd, er);
      chk("store_rdata", rd, 32'd0);
      chk("store_err", 32'(er), 32'd0);
      chk("store_mem", mem_word(1000), 32'hDEADBEEF);
      do_d(1'b0, 32'd1000, 32'd0, rd, er);
      chk("load_rdata", rd, 32'hDEADBEEF);
      repeat (2) @(negedge clk);

      // illegal accesses and the top legal word
      do_d(1'b1, 32'd1002, 32'h12345678, rd, er);
      chk("misaligned_err", 32'(er), 32'd1);
      chk("misaligned_rdata", rd, 32'd0);
      chk("misaligned_mem_lo", mem_word(1000), 32'hDEADBEEF);
      chk("misaligned_mem_hi", mem_word(1004), 32'h4A4B4849);
      do_d(1'b0, 32'd65534, 32'd0, rd, er);
      chk("adr65534_err", 32'(er), 32'd1);
      do_d(1'b0, 32'd65536, 32'd0, rd, er);
      chk("adr65536_err", 32'(er), 32'd1);
      chk("adr65536_rdata", rd, 32'd0);
      do_d(1'b0, 32'd65532, 32'd0, rd, er);
      chk("adr65532_err", 32'(er), 32'd0);
      chk("adr65532_rdata", rd, 32'h5A5B5859);
      repeat (2) @(negedge clk);

      // reset in the middle of a store
      @(negedge clk);
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_adr = 32'd1004; bus.d_wdata = 32'h11111111;
      wait_gnt(1'b1, glat);
      @(negedge clk);
      rst = 1'b0; bus.d_req = 1'b0;
      #1;
      chk("mwr_gated_by_rst", 32'(bus.mwr), 32'd0);
      @(posedge clk); #1;
      chk("midrst_d_gnt", 32'(bus.d_gnt), 32'd0);
      chk("midrst_d_valid", 32'(bus.d_valid), 32'd0);
      chk("midrst_d_rdata", bus.d_rdata, 32'd0);
      chk("midrst_mem_port", bus.adr | bus.d_in, 32'd0);
      @(negedge clk); rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("midrst_no_valid", 32'(bus.d_valid), 32'd0);
      end
      chk("midrst_mem", mem_word(1004), 32'h4A4B4849);

      // back-to-back loads with d_req held
      b2b_exp[0] = 32'hDEADBEEF; b2b_exp[1] = 32'h4A4B4849;
      b2b_exp[2] = 32'h56575455; b2b_exp[3] = 32'h52535051;
      prev_v = 0;
      @(negedge clk);
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_adr = 32'd1000;
      for (int k = 0; k < 4; k++) begin
         wait_gnt(1'b1, glat);
         @(negedge clk);
         if (k < 3) bus.d_adr = 32'd1000 + 32'(4 * (k + 1));
         else bus.d_req = 1'b0;
         wait_valid(1'b1, vlat, rd, er);
         chk("b2b_rdata", rd, b2b_exp[k]);
         if (k > 0) chk("b2b_spacing", 32'(cyc - prev_v), 32'd2);
         prev_v = cyc;
      end
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout t=%0t", $time);
      $fatal(1, "watchdog");
   end
endmodule
